coin_credit_arbiter: RTL

COIN_CREDIT_ARBITER -- requirements
Module: coin_credit_arbiter

---
 rtl/coin_credit_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/coin_credit_arbiter.sv
// coin_credit_arbiter: counts coin insertions per coin type and offers them
// one at a time as credits through a valid/ready output slot.
// Optional feature macro: COIN_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration (nickel -> dime -> quarter); otherwise fixed priority
// quarter > dime > nickel.
module coin_credit_arbiter #(
  parameter int unsigned PEND_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       enable,
  input  logic       flush,
  input  logic       credit_ready,
  output logic       credit_valid,
  output logic [6:0] credit_amount,
  output logic [1:0] credit_coin,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [1:0] PEND_MAX_C = 2'(PEND_MAX);

  // Index 0 = nickel, 1 = dime, 2 = quarter.
  logic [2:0] coin_in;
  logic [2:0] coin_low_reg;  // input was sampled low: a rise now is a coin
  logic [2:0] coin_edge;
  logic [2:0] nonzero;
  logic [2:0] reject_vec;
  logic [2:0] sel;
  logic [2:0] dec;
  logic       slot_free;
  logic       load;
  logic [6:0] load_amount;
  logic [1:0] load_coin;

  assign coin_in   = {quarter, dime, nickel};
  assign coin_edge = coin_in & coin_low_reg;
  assign slot_free = ~credit_valid | credit_ready;
  assign load      = slot_free & enable & (|nonzero);
  assign dec       = load ? sel : 3'b000;
  assign busy      = (|nonzero) | credit_valid;

  // Edge-detect history; cleared by reset so a coin held high through
  // reset release must fall before its next rise is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) coin_low_reg <= 3'b000;
    else     coin_low_reg <= ~coin_in;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_coin
      logic [1:0] cnt_reg;
      logic [1:0] cnt_next;
      logic       full;

      assign full           = (cnt_reg == PEND_MAX_C);
      assign nonzero[gi]    = (cnt_reg != 2'd0);
      assign reject_vec[gi] = coin_edge[gi] & full & ~dec[gi];

      // Pending-count update: edge adds, load subtracts, both cancel.
      always_comb begin
        cnt_next = cnt_reg;
        if (flush)
          cnt_next = 2'd0;
        else if (coin_edge[gi] && !dec[gi] && !full)
          cnt_next = cnt_reg + 2'd1;
        else if (!coin_edge[gi] && dec[gi])
          cnt_next = cnt_reg - 2'd1;
      end

      // Pending-count register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_reg <= 2'd0;
        else     cnt_reg <= cnt_next;
      end
    end
  endgenerate

`ifdef COIN_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_reg;
  logic [1:0] ptr_next;

  // Round-robin pick starting at the pointer.
  always_comb begin
    sel = 3'b000;
    case (ptr_reg)
      2'd1: begin
        if      (nonzero[1]) sel = 3'b010;
        else if (nonzero[2]) sel = 3'b100;
        else if (nonzero[0]) sel = 3'b001;
      end
      2'd2: begin
        if      (nonzero[2]) sel = 3'b100;
        else if (nonzero[0]) sel = 3'b001;
        else if (nonzero[1]) sel = 3'b010;
      end
      default: begin
        if      (nonzero[0]) sel = 3'b001;
        else if (nonzero[1]) sel = 3'b010;
        else if (nonzero[2]) sel = 3'b100;
      end
    endcase
  end

  // Pointer advances to the coin after the one just loaded.
  always_comb begin
    ptr_next = ptr_reg;
    if (load && !flush) begin
      if      (sel[0]) ptr_next = 2'd1;
      else if (sel[1]) ptr_next = 2'd2;
      else if (sel[2]) ptr_next = 2'd0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= 2'd0;
    else     ptr_reg <= ptr_next;
  end
`else
  // Fixed priority pick: quarter first, then dime, then nickel.
  always_comb begin
    sel = 3'b000;
    if      (nonzero[2]) sel = 3'b100;
    else if (nonzero[1]) sel = 3'b010;
    else if (nonzero[0]) sel = 3'b001;
  end
`endif

  // Value and source code of the selected coin.
  always_comb begin
    load_amount = 7'd0;
    load_coin   = 2'b00;
    if (sel[2]) begin
      load_amount = 7'd25;
      load_coin   = 2'b11;
    end else if (sel[1]) begin
      load_amount = 7'd10;
      load_coin   = 2'b10;
    end else if (sel[0]) begin
      load_amount = 7'd5;
      load_coin   = 2'b01;
    end
  end

  // Output slot and reject pulse; flush overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_valid  <= 1'b0;
      credit_amount <= 7'd0;
      credit_coin   <= 2'b00;
      coin_reject   <= 1'b0;
    end else if (flush) begin
      credit_valid  <= 1'b0;
      credit_amount <= 7'd0;
      credit_coin   <= 2'b00;
      coin_reject   <= 1'b0;
    end else begin
      coin_reject <= |reject_vec;
      if (load) begin
        credit_valid  <= 1'b1;
        credit_amount <= load_amount;
        credit_coin   <= load_coin;
      end else if (slot_free) begin
        credit_valid  <= 1'b0;
        credit_amount <= 7'd0;
        credit_coin   <= 2'b00;
      end
    end
  end

endmodule
